// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder: FSM state encoding
// and the data word returned for out-of-range reads.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } dsram_state_e;

  localparam logic [31:0] DSRAM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_sram_responder_bank.sv
// dsram_bank: 2**ADDR_W x 32 word array with byte-lane writes and a registered
// read port that holds its value until the next read.
module dsram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Byte-lane writes; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en && wen[i]) begin
        mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read port only loads on a read, so writes leave the last read value visible.
  always_comb begin
    rdata_d = rdata_q;
    if (en && (wen == 4'b0000)) begin
      rdata_d = mem_q[idx];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data-SRAM interface with optional wait states.
// Optional macro DSRAM_RANGE_CHK_EN enables the upper-address range check.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int CNT_W = (WAIT_CYCLES <= 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  dsram_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  lat_wen_q, lat_wen_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;

  logic        acc_en_s;
  logic [3:0]  acc_wen_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic        bank_en_s;
  logic [31:0] bank_rdata_s;
  logic        unused_s;

  // Request sequencing: pass-through when WAIT_CYCLES is 0, else IDLE/BUSY/DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_wen_d   = lat_wen_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    stallreq    = 1'b0;
    acc_en_s    = 1'b0;
    acc_wen_s   = data_sram_wen;
    acc_addr_s  = data_sram_addr;
    acc_wdata_s = data_sram_wdata;
    if (WAIT_CYCLES == 0) begin
      state_d  = ST_IDLE;
      acc_en_s = data_sram_en & ~rst;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_sram_en) begin
            stallreq    = 1'b1;
            lat_wen_d   = data_sram_wen;
            lat_addr_d  = data_sram_addr;
            lat_wdata_d = data_sram_wdata;
            cnt_d       = CNT_W'(WAIT_CYCLES - 1);
            state_d     = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          stallreq    = 1'b1;
          acc_wen_s   = lat_wen_q;
          acc_addr_s  = lat_addr_q;
          acc_wdata_s = lat_wdata_q;
          if (cnt_q == '0) begin
            // A reset in the final BUSY cycle drops the access.
            acc_en_s = ~rst;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, wait counter and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_wen_q   <= 4'b0000;
      lat_addr_q  <= 32'h0000_0000;
      lat_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_wen_q   <= lat_wen_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  assign unused_s = ^{acc_addr_s[1:0], acc_addr_s[31:ADDR_W+2]};

`ifdef DSRAM_RANGE_CHK_EN
  logic oor_s;
  logic err_sel_q, err_sel_d;
  logic addr_err_q;

  assign oor_s     = |acc_addr_s[31:ADDR_W+2];
  assign bank_en_s = acc_en_s & ~oor_s;

  // err_sel only changes on a completed read so the error word persists like real data.
  always_comb begin
    err_sel_d = err_sel_q;
    if (acc_en_s && (acc_wen_s == 4'b0000)) begin
      err_sel_d = oor_s;
    end else begin
      err_sel_d = err_sel_q;
    end
  end

  // Error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      err_sel_q  <= err_sel_d;
      addr_err_q <= acc_en_s & oor_s;
    end
  end

  assign data_sram_rdata = err_sel_q ? DSRAM_ERR_DATA : bank_rdata_s;
  assign addr_err        = addr_err_q;
`else
  assign bank_en_s       = acc_en_s;
  assign data_sram_rdata = bank_rdata_s;
  assign addr_err        = 1'b0;
`endif

  dsram_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .en    (bank_en_s),
    .wen   (acc_wen_s),
    .idx   (acc_addr_s[ADDR_W+1:2]),
    .wdata (acc_wdata_s),
    .rdata (bank_rdata_s)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: a zero-wait instance driven from a vector table and a
// three-wait-state instance exercised with hand-written sequences.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3;
  logic        aerr0, aerr3;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata0), .stallreq(stall0), .addr_err(aerr0)
  );

  data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata3), .stallreq(stall3), .addr_err(aerr3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  // One access on the wait-state instance: request held through DONE, then dropped.
  task automatic acc3(input string nm, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    drive(1'b1, w, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall3) begin
        stalls++;
        @(posedge clk);
      end else begin
        break;
      end
    end
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'd4);
    chk({nm, "_done_rdata"}, rdata3, exp_rd);
    @(posedge clk); #1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    chk({nm, "_after_done_stall"}, {31'd0, stall3}, 32'd0);
    chk({nm, "_after_done_rdata"}, rdata3, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000};
    vecs[1]  = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'h1122_3344};
    vecs[2]  = '{1'b1, 4'b0100, 32'h0000_0010, 32'hAABB_CCDD, 32'h1122_3344};
    vecs[3]  = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'h11BB_3344};
    vecs[4]  = '{1'b1, 4'b1111, 32'h0000_0014, 32'h5566_7788, 32'h11BB_3344};
    vecs[5]  = '{1'b1, 4'b0000, 32'h0000_0014, 32'h0000_0000, 32'h5566_7788};
    vecs[6]  = '{1'b1, 4'b1111, 32'h0000_0000, 32'hA0A0_A0A0, 32'h5566_7788};
    vecs[7]  = '{1'b1, 4'b1111, 32'h0000_0004, 32'hB1B1_B1B1, 32'h5566_7788};
    vecs[8]  = '{1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'hA0A0_A0A0};
    vecs[9]  = '{1'b1, 4'b0000, 32'h0000_0004, 32'h0000_0000, 32'hB1B1_B1B1};
    vecs[10] = '{1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'hA0A0_A0A0};
    vecs[11] = '{1'b1, 4'b0000, 32'h0000_0004, 32'h0000_0000, 32'hB1B1_B1B1};
    vecs[12] = '{1'b0, 4'b0000, 32'h0000_0010, 32'h0000_0000, 32'hB1B1_B1B1};
    vecs[13] = '{1'b1, 4'b0001, 32'h0000_0006, 32'h0000_00FF, 32'hB1B1_B1B1};
    vecs[14] = '{1'b1, 4'b0000, 32'h0000_0007, 32'h0000_0000, 32'hB1B1_B1FF};

    rst = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_stall0", {31'd0, stall0}, 32'd0);
    chk("reset_aerr0", {31'd0, aerr0}, 32'd0);
    chk("reset_rdata3", rdata3, 32'h0);
    chk("reset_stall3", {31'd0, stall3}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("w0_vec%0d_stall", i), {31'd0, stall0}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("w0_vec%0d_rdata", i), rdata0, vecs[i].exp_rdata);
      chk($sformatf("w0_vec%0d_aerr", i), {31'd0, aerr0}, 32'd0);
    end

`ifdef DSRAM_RANGE_CHK_EN
    drive(1'b1, 4'b1111, 32'h0000_4000, 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b1, 4'b0000, 32'h0000_4000, 32'h0);
    @(posedge clk); #1;
    chk("oor_read_rdata", rdata0, 32'hDEAD_BEEF);
    chk("oor_read_aerr", {31'd0, aerr0}, 32'd1);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("oor_pulse_end", {31'd0, aerr0}, 32'd0);
    chk("oor_rdata_hold", rdata0, 32'hDEAD_BEEF);
    drive(1'b1, 4'b0000, 32'h0000_0000, 32'h0);
    @(posedge clk); #1;
    chk("oor_write_suppressed", rdata0, 32'hA0A0_A0A0);
    chk("inrange_aerr", {31'd0, aerr0}, 32'd0);
`else
    drive(1'b1, 4'b0000, 32'h0000_4010, 32'h0);
    @(posedge clk); #1;
    chk("alias_read_rdata", rdata0, 32'h11BB_3344);
    chk("alias_read_aerr", {31'd0, aerr0}, 32'd0);
`endif
    drive(1'b0, 4'b0000, 32'h0, 32'h0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("w3_reset_stall", {31'd0, stall3}, 32'd0);
    chk("w3_reset_rdata", rdata3, 32'h0);

    acc3("w3_write", 4'b1111, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000);
    acc3("w3_read", 4'b0000, 32'h0000_0008, 32'h0, 32'h1234_5678);

    @(posedge clk); #1;
    drive(1'b1, 4'b1111, 32'h0000_0008, 32'hFFFF_FFFF);
    #1;
    chk("w3_same_cycle_stall", {31'd0, stall3}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("w3_midbusy_rst_stall", {31'd0, stall3}, 32'd0);
    chk("w3_midbusy_rst_rdata", rdata3, 32'h0);
    acc3("w3_read_after_rst", 4'b0000, 32'h0000_0008, 32'h0, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
